memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of EX: consumes the EX_MEM_*
//  register, performs lw/sw through a req/ack data-memory port and fills the MEM_WB_* register for WB.
//  Raises mem_stall_c while an access is outstanding, so EX (and all earlier stages) hold their state.
// PARAMETERS
//  TIMEOUT_CYCLES  16  WAIT cycles without dmem_ack before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clock            in   1   single clock, rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  EX_MEM_result    in   32  ALU result; effective address for lw/sw
//  EX_MEM_B         in   32  store data (rt value)
//  EX_MEM_dest      in   5   destination register
//  EX_MEM_op        in   6   opcode
//  EX_MEM_valid     in   1   register-write qualifier from EX
//  dmem_req         out  1   access request; level, held until ack
//  dmem_we          out  1   1=store, 0=load; valid when dmem_req=1
//  dmem_addr        out  32  word address (byte address, bits[1:0]=0)
//  dmem_wdata       out  32  store data
//  dmem_rdata       in   32  load data; valid in the dmem_ack cycle
//  dmem_ack         in   1   access complete; may assert in the same cycle as the first req
//  MEM_WB_result    out  32  load data or passed-through ALU result
//  MEM_WB_dest      out  5   destination register
//  MEM_WB_op        out  6   opcode
//  MEM_WB_valid     out  1   WB writes MEM_WB_result to MEM_WB_dest
//  mem_stall_c      out  1   combinational stall to EX
//  mem_error        out  1   sticky: misaligned access or timeout
// BEHAVIOUR
//  - mem_op = EX_MEM_op is `lw (6'h23) or `sw (6'h2B). aligned = (EX_MEM_result[1:0]==2'b00).
//  - FSM IDLE/WAIT. Reset: state=IDLE. All MEM_WB_* outputs reset to 0. mem_error resets to 0.
//  - IDLE with mem_op&aligned: dmem_req=1 (combinational). dmem_addr/wdata/we come from EX_MEM_*.
//    If dmem_ack=1 in the same cycle, the access completes with 0 stall cycles and the FSM stays in
//    IDLE. Otherwise the FSM goes to WAIT and latches addr, wdata and we.
//  - WAIT: dmem_req=1 with the latched addr/wdata/we. On dmem_ack, go to IDLE.
//  - mem_stall_c = (IDLE & mem_op & aligned & ~dmem_ack) | (WAIT & ~dmem_ack).
//  - Completion cycle = the cycle in which ack is seen. The stall drops in that cycle, so EX advances
//    on the same edge. A completed access is never reissued.
//  - MEM_WB update, every edge when not in reset:
//      stalled           -> MEM_WB_valid<=0 (bubble); other MEM_WB_* fields are don't-care but held
//      lw complete       -> result<=dmem_rdata, valid<=1, dest/op<=EX_MEM
//      sw complete       -> valid<=0, result<=0, dest/op<=EX_MEM
//      misaligned lw/sw  -> no request, no stall, valid<=0, mem_error<=1
//      other ops         -> result/dest/op/valid <= EX_MEM_* passthrough (beq/bne arrive valid=0)
//  - Load latency: 1 + wait-states edges from EX_MEM capture to MEM_WB. Store: same, with no WB write.
//  - dmem_req is gated by reset_n. Asserting reset while in WAIT immediately drops dmem_req and
//    forces IDLE. A late ack after reset is ignored.
//  - dmem_ack while dmem_req=0 is ignored.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    - 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
//    - At count==TIMEOUT_CYCLES-1 with no ack: dmem_req drops on the next edge, FSM->IDLE,
//      mem_stall_c=0 that cycle, MEM_WB_valid<=0, mem_error<=1.
//  MEM_TIMEOUT_EN undefined:
//    - no counter; WAIT lasts until ack (unbounded).
//    - mem_error is set only by a misaligned access.
// TESTING
//  1 lw addr 0x40, ack same cycle, rdata 0xDEADBEEF, dest 5 -> no stall; next edge
//    MEM_WB_result=0xDEADBEEF, MEM_WB_dest=5, MEM_WB_valid=1
//  2 sw addr 0x80, B=0x1234, ack after 3 cycles -> stall 3 cycles, dmem_we=1, dmem_wdata=0x1234 held
//    stable, 3 bubbles with valid=0, then valid=0 for the sw, exactly one req burst
//  3 add result 0x7, dest 3, valid 1 -> MEM_WB passthrough next edge, dmem_req never 1
//  4 lw addr 0x42 -> dmem_req=0, no stall, MEM_WB_valid=0, mem_error=1 and sticky until reset
//  5 reset_n low during WAIT of lw -> dmem_req=0 immediately, MEM_WB_*=0, stall=0; an ack after
//    reset_n rises changes nothing
//  6 [MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4] lw with no ack -> stall exactly 4 cycles, then req drops,
//    mem_error=1, MEM_WB_valid=0

Source files
------------

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: lw/sw over a req/ack data-memory port, fills MEM_WB_*.
// Optional `MEM_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYCLES cycles without dmem_ack.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] EX_MEM_result,
    input  logic [31:0] EX_MEM_B,
    input  logic [4:0]  EX_MEM_dest,
    input  logic [5:0]  EX_MEM_op,
    input  logic        EX_MEM_valid,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] MEM_WB_result,
    output logic [4:0]  MEM_WB_dest,
    output logic [5:0]  MEM_WB_op,
    output logic        MEM_WB_valid,
    output logic        mem_stall_c,
    output logic        mem_error
);

    localparam logic [5:0] LP_OP_LW = 6'h23;
    localparam logic [5:0] LP_OP_SW = 6'h2B;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("memory_stage: TIMEOUT_CYCLES must be within 1..256");
    end

    logic [0:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;

    logic w_is_lw;
    logic w_is_sw;
    logic w_mem_op;
    logic w_aligned;
    logic w_in_wait;
    logic w_start;
    logic w_misaligned;
    logic w_done;
    logic w_abort;
    logic w_stall;

    assign w_is_lw      = (EX_MEM_op == LP_OP_LW);
    assign w_is_sw      = (EX_MEM_op == LP_OP_SW);
    assign w_mem_op     = w_is_lw | w_is_sw;
    assign w_aligned    = (EX_MEM_result[1:0] == 2'b00);
    assign w_in_wait    = (r_state == S_WAIT);
    assign w_start      = (r_state == S_IDLE) & w_mem_op & w_aligned;
    assign w_misaligned = (r_state == S_IDLE) & w_mem_op & ~w_aligned;

    // Gating by reset_n drops the request the instant reset asserts, even mid-WAIT.
    assign dmem_req   = reset_n & (w_start | w_in_wait);
    assign dmem_we    = w_in_wait ? r_we    : w_is_sw;
    assign dmem_addr  = w_in_wait ? r_addr  : EX_MEM_result;
    assign dmem_wdata = w_in_wait ? r_wdata : EX_MEM_B;

    assign w_done = dmem_req & dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;

    assign w_abort = w_in_wait & ~dmem_ack & (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_start & ~dmem_ack) begin
            r_cnt <= '0;
        end else if (w_in_wait & ~dmem_ack) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    assign w_stall     = dmem_req & ~dmem_ack & ~w_abort;
    assign mem_stall_c = w_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start & ~dmem_ack) begin
                        r_state <= S_WAIT;
                        r_addr  <= EX_MEM_result;
                        r_wdata <= EX_MEM_B;
                        r_we    <= w_is_sw;
                    end
                end
                default: begin
                    if (dmem_ack | w_abort) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            MEM_WB_result <= '0;
            MEM_WB_dest   <= '0;
            MEM_WB_op     <= '0;
            MEM_WB_valid  <= 1'b0;
        end else if (w_stall) begin
            MEM_WB_valid <= 1'b0;
        end else if (w_done) begin
            MEM_WB_dest <= EX_MEM_dest;
            MEM_WB_op   <= EX_MEM_op;
            if (dmem_we) begin
                MEM_WB_result <= '0;
                MEM_WB_valid  <= 1'b0;
            end else begin
                MEM_WB_result <= dmem_rdata;
                MEM_WB_valid  <= 1'b1;
            end
        end else if (w_misaligned | w_abort) begin
            MEM_WB_result <= EX_MEM_result;
            MEM_WB_dest   <= EX_MEM_dest;
            MEM_WB_op     <= EX_MEM_op;
            MEM_WB_valid  <= 1'b0;
        end else begin
            MEM_WB_result <= EX_MEM_result;
            MEM_WB_dest   <= EX_MEM_dest;
            MEM_WB_op     <= EX_MEM_op;
            MEM_WB_valid  <= EX_MEM_valid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_error <= 1'b0;
        end else if (w_misaligned | w_abort) begin
            mem_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: cycle model of the MEM-stage rules plus directed literal checks.
module tb_memory_stage;

    localparam int unsigned TO = 4;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] EX_MEM_result = '0;
    logic [31:0] EX_MEM_B = '0;
    logic [4:0]  EX_MEM_dest = '0;
    logic [5:0]  EX_MEM_op = '0;
    logic        EX_MEM_valid = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] MEM_WB_result;
    logic [4:0]  MEM_WB_dest;
    logic [5:0]  MEM_WB_op;
    logic        MEM_WB_valid;
    logic        mem_stall_c;
    logic        mem_error;

    int n_checks = 0;
    int n_errs   = 0;
    int bursts   = 0;
    logic prev_req = 1'b0;

    always #5 clock = ~clock;

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .EX_MEM_result(EX_MEM_result), .EX_MEM_B(EX_MEM_B), .EX_MEM_dest(EX_MEM_dest),
        .EX_MEM_op(EX_MEM_op), .EX_MEM_valid(EX_MEM_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .MEM_WB_result(MEM_WB_result), .MEM_WB_dest(MEM_WB_dest), .MEM_WB_op(MEM_WB_op),
        .MEM_WB_valid(MEM_WB_valid), .mem_stall_c(mem_stall_c), .mem_error(mem_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access is "wanted" whenever an aligned lw/sw sits in EX_MEM;
    // m_age counts how many cycles it has already been kept waiting.
    logic [31:0] m_result;
    logic [4:0]  m_dest;
    logic [5:0]  m_op;
    logic        m_valid, m_known, m_error;
    int unsigned m_age;

    function automatic logic f_is_mem();
        return (EX_MEM_op == OP_LW) || (EX_MEM_op == OP_SW);
    endfunction

    function automatic logic f_req();
        return reset_n && f_is_mem() && (EX_MEM_result[1:0] == 2'b00);
    endfunction

    function automatic logic f_abort();
`ifdef MEM_TIMEOUT_EN
        return f_req() && !dmem_ack && (m_age == TO);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic f_stall();
        return f_req() && !dmem_ack && !f_abort();
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_result <= '0; m_dest <= '0; m_op <= '0;
            m_valid <= 1'b0; m_known <= 1'b1; m_error <= 1'b0; m_age <= 0;
        end else if (f_stall()) begin
            m_valid <= 1'b0;
            m_age   <= m_age + 1;
        end else begin
            m_age   <= 0;
            m_dest  <= EX_MEM_dest;
            m_op    <= EX_MEM_op;
            m_known <= 1'b1;
            if (f_req() && dmem_ack) begin
                m_result <= (EX_MEM_op == OP_SW) ? 32'h0 : dmem_rdata;
                m_valid  <= (EX_MEM_op == OP_LW);
            end else if (f_is_mem()) begin
                m_valid <= 1'b0;
                m_error <= 1'b1;
                m_known <= 1'b0;
            end else begin
                m_result <= EX_MEM_result;
                m_valid  <= EX_MEM_valid;
            end
        end
    end

    always @(negedge clock) begin
        chk("req", 32'(dmem_req), 32'(f_req()));
        chk("stall", 32'(mem_stall_c), 32'(f_stall()));
        if (f_req()) begin
            chk("we", 32'(dmem_we), 32'(EX_MEM_op == OP_SW));
            chk("addr", dmem_addr, EX_MEM_result);
            if (EX_MEM_op == OP_SW) chk("wdata", dmem_wdata, EX_MEM_B);
        end
        chk("wb_valid", 32'(MEM_WB_valid), 32'(m_valid));
        chk("error", 32'(mem_error), 32'(m_error));
        if (m_known) begin
            chk("wb_result", MEM_WB_result, m_result);
            chk("wb_dest", 32'(MEM_WB_dest), 32'(m_dest));
            chk("wb_op", 32'(MEM_WB_op), 32'(m_op));
        end
        if (dmem_req && !prev_req) bursts++;
        prev_req = dmem_req;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ex(input logic [5:0] op, input logic [31:0] res, input logic [31:0] b,
                          input logic [4:0] dest, input logic valid);
        EX_MEM_op = op; EX_MEM_result = res; EX_MEM_B = b; EX_MEM_dest = dest; EX_MEM_valid = valid;
    endtask

    task automatic nop();
        set_ex(6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    initial begin
        int b0;
        int stalls;
        #1 reset_n = 1'b0;
        cyc(); cyc();
        chk("rst_valid", 32'(MEM_WB_valid), 32'd0);
        chk("rst_result", MEM_WB_result, 32'h0);
        chk("rst_error", 32'(mem_error), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        reset_n = 1'b1;
        cyc();

        // lw with zero wait states
        set_ex(OP_LW, 32'h40, 32'h0, 5'd5, 1'b1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_req", 32'(dmem_req), 32'd1);
        chk("t1_stall", 32'(mem_stall_c), 32'd0);
        cyc();
        nop(); dmem_ack = 1'b0; dmem_rdata = '0;
        chk("t1_result", MEM_WB_result, 32'hDEADBEEF);
        chk("t1_dest", 32'(MEM_WB_dest), 32'd5);
        chk("t1_valid", 32'(MEM_WB_valid), 32'd1);
        cyc();

        // sw with three wait states
        b0 = bursts;
        set_ex(OP_SW, 32'h80, 32'h1234, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall", 32'(mem_stall_c), 32'd1);
            chk("t2_we", 32'(dmem_we), 32'd1);
            chk("t2_wdata", dmem_wdata, 32'h1234);
            cyc();
            chk("t2_bubble", 32'(MEM_WB_valid), 32'd0);
        end
        dmem_ack = 1'b1;
        #1;
        chk("t2_ack_stall", 32'(mem_stall_c), 32'd0);
        cyc();
        nop(); dmem_ack = 1'b0;
        chk("t2_valid", 32'(MEM_WB_valid), 32'd0);
        chk("t2_op", 32'(MEM_WB_op), 32'h2B);
        cyc();
        chk("t2_bursts", 32'(bursts - b0), 32'd1);

        // ALU passthrough
        set_ex(6'h00, 32'h7, 32'h0, 5'd3, 1'b1);
        #1;
        chk("t3_req", 32'(dmem_req), 32'd0);
        cyc();
        nop();
        chk("t3_result", MEM_WB_result, 32'h7);
        chk("t3_dest", 32'(MEM_WB_dest), 32'd3);
        chk("t3_valid", 32'(MEM_WB_valid), 32'd1);

        // lw with one wait state
        set_ex(OP_LW, 32'h44, 32'h0, 5'd6, 1'b1);
        cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        cyc();
        nop(); dmem_ack = 1'b0;
        chk("t7_result", MEM_WB_result, 32'hCAFEF00D);
        chk("t7_valid", 32'(MEM_WB_valid), 32'd1);
        cyc();

        // misaligned lw; later a stray ack with no request
        set_ex(OP_LW, 32'h42, 32'h0, 5'd4, 1'b1);
        #1;
        chk("t4_req", 32'(dmem_req), 32'd0);
        chk("t4_stall", 32'(mem_stall_c), 32'd0);
        cyc();
        nop();
        chk("t4_valid", 32'(MEM_WB_valid), 32'd0);
        chk("t4_error", 32'(mem_error), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555AAAA;
        repeat (3) cyc();
        dmem_ack = 1'b0;
        chk("t4_sticky", 32'(mem_error), 32'd1);

        // reset in the middle of a WAIT
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("t5_err_clr", 32'(mem_error), 32'd0);
        set_ex(OP_LW, 32'h100, 32'h0, 5'd7, 1'b1);
        cyc(); cyc();
        reset_n = 1'b0;
        nop();
        #1;
        chk("t5_req", 32'(dmem_req), 32'd0);
        chk("t5_stall", 32'(mem_stall_c), 32'd0);
        chk("t5_valid", 32'(MEM_WB_valid), 32'd0);
        chk("t5_result", MEM_WB_result, 32'h0);
        cyc();
        reset_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h00000BAD;
        cyc();
        dmem_ack = 1'b0;
        chk("t5_late_valid", 32'(MEM_WB_valid), 32'd0);
        chk("t5_late_result", MEM_WB_result, 32'h0);
        chk("t5_late_req", 32'(dmem_req), 32'd0);

        // lw that never sees an ack
        set_ex(OP_LW, 32'h200, 32'h0, 5'd9, 1'b1);
        stalls = 0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!mem_stall_c) break;
            stalls++;
            cyc();
        end
        chk("t6_stalls", 32'(stalls), 32'(TO));
        chk("t6_req_last", 32'(dmem_req), 32'd1);
        cyc();
        nop();
        #1;
        chk("t6_req_drop", 32'(dmem_req), 32'd0);
        chk("t6_error", 32'(mem_error), 32'd1);
        chk("t6_valid", 32'(MEM_WB_valid), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_stall_c) stalls++;
            cyc();
        end
        chk("t6_unbounded", 32'(stalls), 32'd20);
        dmem_ack = 1'b1; dmem_rdata = 32'h13572468;
        cyc();
        nop(); dmem_ack = 1'b0;
        chk("t6_result", MEM_WB_result, 32'h13572468);
        chk("t6_error", 32'(mem_error), 32'd0);
`endif
        cyc(); cyc();
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
